// File: rtl/mem_ctrl.sv
// Single-port synchronous RAM with valid/ready requests, byte enables,
// fixed read latency, post-reset zeroing and out-of-range flagging.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   req_valid/ready request handshake
//   req_wr          1 = write, 0 = read
//   req_addr        word address
//   req_wdata       write data
//   req_be          per-byte write enables
//   rsp_valid       one-cycle pulse per accepted read
//   rsp_rdata       read data (0 when rsp_valid=0)
//   rsp_err         read address was >= DEPTH
//   init_done       clear sequence finished
module mem_ctrl #(
  parameter int DWIDTH         = 32,
  parameter int AWIDTH         = 5,
  parameter int DEPTH          = 32,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [AWIDTH-1:0]   req_addr,
  input  logic [DWIDTH-1:0]   req_wdata,
  input  logic [DWIDTH/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DWIDTH-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int BWIDTH = DWIDTH / 8;
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so DEPTH = 2^AWIDTH is representable.
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] LAST_W  = (AWIDTH+1)'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam state_t RST_STATE =
    (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  state_t          state_q;
  state_t          state_d;
  logic [AWIDTH:0] cnt_q;
  logic            clr_we;

  logic            acc;
  logic            rd_acc;
  logic            wr_acc;
  logic            in_range;
  logic [IW-1:0]   req_idx;
  logic [IW-1:0]   clr_idx;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              vld_q [RD_LATENCY];
  logic              err_q [RD_LATENCY];
  logic [DWIDTH-1:0] dat_q [RD_LATENCY];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == CLEAR) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR: if (cnt_q == LAST_W) state_d = READY;
      READY: state_d = READY;
      default: state_d = RST_STATE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = 1'b0;
    init_done = 1'b0;
    clr_we    = 1'b0;
    unique case (state_q)
      CLEAR: clr_we = 1'b1;
      READY: begin
        req_ready = 1'b1;
        init_done = 1'b1;
      end
      default: clr_we = 1'b0;
    endcase
  end

  assign acc      = req_valid & req_ready;
  assign rd_acc   = acc & ~req_wr;
  assign wr_acc   = acc & req_wr;
  assign in_range = {1'b0, req_addr} < DEPTH_W;
  assign req_idx  = req_addr[IW-1:0];
  assign clr_idx  = cnt_q[IW-1:0];

  // Array has no reset; only the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_acc && in_range) begin
      for (int b = 0; b < BWIDTH; b++) begin
        if (req_be[b]) begin
          mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Stage 0 samples the array at acceptance; later stages delay it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        err_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_acc;
      err_q[0] <= rd_acc & ~in_range;
      dat_q[0] <= (rd_acc && in_range) ? mem[req_idx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rsp_valid = vld_q[RD_LATENCY-1];
  assign rsp_err   = vld_q[RD_LATENCY-1] & err_q[RD_LATENCY-1];
  assign rsp_rdata = vld_q[RD_LATENCY-1] ? dat_q[RD_LATENCY-1] : '0;

endmodule
